// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: per-channel runtime divisors, one-cycle ticks and 50% square outputs.
// Optional phase-alignment input sync_start is enabled by defining CLK_ENABLE_GEN_SYNC_START_EN.
module clk_enable_gen #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 24,
    parameter int CH_W        = 2,
    parameter int DEFAULT_DIV = 1
) (
    input  logic              board_clk,
    input  logic              reset,
    input  logic              en,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_restart,
`ifdef CLK_ENABLE_GEN_SYNC_START_EN
    input  logic              sync_start,
`endif
    output logic              cfg_err,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [CNT_W-1:0]  div_q    [NUM_CH];
    logic [CNT_W-1:0]  div_d    [NUM_CH];
    logic [CNT_W-1:0]  shadow_q [NUM_CH];
    logic [CNT_W-1:0]  shadow_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_d;
    logic [NUM_CH-1:0] sq_q;
    logic [NUM_CH-1:0] sq_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;
    logic              cfg_err_q;
    logic              cfg_err_d;

    logic              ch_in_range_s;
    logic [NUM_CH-1:0] ch_hit_s;
    logic [NUM_CH-1:0] wrap_s;

    // Decode the configuration write into a per-channel select and an out-of-range flag.
    always_comb begin
        ch_in_range_s = ({1'b0, cfg_ch} < NUM_CH_L);
        cfg_err_d     = cfg_wr & ~ch_in_range_s;
        ch_hit_s      = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            ch_hit_s[i] = cfg_wr & ch_in_range_s & (cfg_ch == CH_W'(i));
        end
    end

    // Per-channel next-state: restart beats counting; a deferred write lands after any same-cycle wrap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]    = cnt_q[i];
            div_d[i]    = div_q[i];
            shadow_d[i] = shadow_q[i];
            pend_d[i]   = pend_q[i];
            sq_d[i]     = sq_q[i];
            tick_d[i]   = 1'b0;
            wrap_s[i]   = en & (cnt_q[i] == div_q[i]);

            if (ch_hit_s[i] && cfg_restart) begin
                div_d[i]    = cfg_div;
                shadow_d[i] = cfg_div;
                cnt_d[i]    = CNT_ZERO;
                sq_d[i]     = 1'b0;
                pend_d[i]   = 1'b0;
            end else begin
                if (wrap_s[i]) begin
                    cnt_d[i]  = CNT_ZERO;
                    tick_d[i] = 1'b1;
                    sq_d[i]   = ~sq_q[i];
                    div_d[i]  = pend_q[i] ? shadow_q[i] : div_q[i];
                    pend_d[i] = 1'b0;
                end else if (en) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end else begin
                    cnt_d[i] = cnt_q[i];
                end

                // The wrap above consumed the old shadow; this write becomes the next pending value.
                if (ch_hit_s[i]) begin
                    shadow_d[i] = cfg_div;
                    pend_d[i]   = 1'b1;
                end else begin
                    shadow_d[i] = shadow_q[i];
                end
            end

`ifdef CLK_ENABLE_GEN_SYNC_START_EN
            // Alignment pulse zeroes phase on every channel and commits any waiting divisor.
            if (sync_start) begin
                cnt_d[i]  = CNT_ZERO;
                sq_d[i]   = 1'b0;
                tick_d[i] = 1'b0;
                if (!(ch_hit_s[i] && cfg_restart)) begin
                    div_d[i]  = pend_q[i] ? shadow_q[i] : div_d[i];
                    pend_d[i] = ch_hit_s[i];
                end else begin
                    pend_d[i] = 1'b0;
                end
            end else begin
                tick_d[i] = tick_d[i];
            end
`endif
        end
    end

    // Channel state registers.
    always_ff @(posedge board_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= CNT_ZERO;
                div_q[i]    <= DIV_RST;
                shadow_q[i] <= DIV_RST;
            end
            pend_q    <= {NUM_CH{1'b0}};
            sq_q      <= {NUM_CH{1'b0}};
            tick_q    <= {NUM_CH{1'b0}};
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                div_q[i]    <= div_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            pend_q    <= pend_d;
            sq_q      <= sq_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err     = cfg_err_q;
    assign cfg_pending = pend_q;
    assign tick        = tick_q;
    assign sq          = sq_q;

endmodule
